// File: rtl/ifetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch queue.
package ifetch_queue_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_queue_if.sv
// Fetch-side bus bundle: imem request/response, EX redirect and decode handshake.
interface ifetch_queue_if;
  import ifetch_queue_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;

  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, if_ready
  );

endinterface

// File: rtl/ifetch_queue_fifo.sv
// Circular buffer with wrap-bit pointers; flush dominates push and pop.
module ifetch_queue_fifo
  import ifetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         T_ENTRY = fetch_entry_t
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_push,
  input  logic                 i_pop,
  input  logic                 i_flush,
  input  T_ENTRY               i_wdata,
  output T_ENTRY               o_rdata,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  T_ENTRY      r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_do_push;
  logic        w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/ifetch_queue.sv
// Fetch stage: owns the PC, issues credit-limited imem requests, queues {pc, instr} for decode.
// Optional IFQ_BYPASS_EN forwards a response straight to decode when the queue is empty.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
  input  logic           clk,
  input  logic           reset,
  ifetch_queue_if.master bus
);

  localparam int unsigned     CW       = $clog2(DEPTH) + 1;
  localparam logic [0:0]      ST_FETCH = 1'b0;
  localparam logic [0:0]      ST_DRAIN = 1'b1;
  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(INSTR_BYTES);
  localparam logic [XLEN-1:0] PC_MASK  = ~(PC_STEP - XLEN'(1));

  logic [0:0]      r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, r_rsp_pc, w_redirect_pc;
  logic [CW-1:0]   r_outstanding, r_drop_cnt, w_out_nxt, w_drop_nxt, w_count;
  logic            w_req_valid, w_req_fire, w_rsp_accept, w_push, w_pop;
  logic            w_if_valid, w_fifo_empty, w_fifo_full;
  logic [XLEN-1:0] w_if_pc, w_if_instr;
  fetch_entry_t    w_wdata, w_head;

  assign w_redirect_pc = bus.redirect_pc & PC_MASK;

  // Credit check, drain bookkeeping and next state.
  always_comb begin
    w_state_nxt  = r_state;
    w_req_valid  = !reset && (r_state == ST_FETCH) &&
                   (((CW+1)'(w_count) + (CW+1)'(r_outstanding)) < (CW+1)'(DEPTH));
    w_req_fire   = w_req_valid && bus.imem_req_ready;
    w_out_nxt    = r_outstanding + CW'(w_req_fire) - CW'(bus.imem_rsp_valid);
    w_rsp_accept = bus.imem_rsp_valid && (r_drop_cnt == '0) && !bus.redirect_valid;
    w_drop_nxt   = r_drop_cnt;
    if (bus.redirect_valid) begin
      w_drop_nxt = w_out_nxt;
    end else if (bus.imem_rsp_valid && (r_drop_cnt != '0)) begin
      w_drop_nxt = r_drop_cnt - CW'(1);
    end
    case (r_state)
      ST_FETCH: if (bus.redirect_valid && (w_out_nxt != '0)) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_drop_nxt == '0) w_state_nxt = ST_FETCH;
      default:  w_state_nxt = ST_FETCH;
    endcase
  end

  // Decode-side view of the head and queue write control.
  always_comb begin
    w_wdata.pc    = r_rsp_pc;
    w_wdata.instr = bus.imem_rsp_data;
`ifdef IFQ_BYPASS_EN
    w_if_valid = !reset && (!w_fifo_empty || w_rsp_accept);
    w_if_pc    = '0;
    w_if_instr = '0;
    if (!w_fifo_empty) begin
      w_if_pc    = w_head.pc;
      w_if_instr = w_head.instr;
    end else if (w_rsp_accept) begin
      w_if_pc    = r_rsp_pc;
      w_if_instr = bus.imem_rsp_data;
    end
    w_pop  = !reset && !w_fifo_empty && bus.if_ready && !bus.redirect_valid;
    w_push = w_rsp_accept && !(w_fifo_empty && bus.if_ready);
`else
    w_if_valid = !reset && !w_fifo_empty;
    w_if_pc    = w_if_valid ? w_head.pc    : '0;
    w_if_instr = w_if_valid ? w_head.instr : '0;
    w_pop      = w_if_valid && bus.if_ready && !bus.redirect_valid;
    w_push     = w_rsp_accept;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_FETCH;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_outstanding <= w_out_nxt;
      r_drop_cnt    <= w_drop_nxt;
      if (bus.redirect_valid) begin
        r_pc     <= w_redirect_pc;
        r_rsp_pc <= w_redirect_pc;
      end else begin
        if (w_req_fire)   r_pc     <= r_pc + PC_STEP;
        if (w_rsp_accept) r_rsp_pc <= r_rsp_pc + PC_STEP;
      end
    end
  end

  // Credits reserve a slot for every outstanding word, so this can only trip on a bug.
  always_ff @(posedge clk) begin
    if (!reset) assert (!(w_push && w_fifo_full && !w_pop));
  end

  ifetch_queue_fifo #(
    .DEPTH   (DEPTH),
    .T_ENTRY (fetch_entry_t)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bus.redirect_valid),
    .i_wdata (w_wdata),
    .o_rdata (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_count)
  );

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_pc;
  assign bus.if_valid       = w_if_valid;
  assign bus.if_pc          = w_if_pc;
  assign bus.if_instr       = w_if_instr;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: fixed-latency imem model, redirect, stall and wrap cases.
module tb_ifetch_queue;

  localparam int unsigned DEPTH = 4;
`ifdef IFQ_BYPASS_EN
  localparam int T1_FIRST_POP = 1;
`else
  localparam int T1_FIRST_POP = 2;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ifetch_queue_if bus ();

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc;
  int lat;
  logic rdy_req, rdy_if, redir_v;
  logic [31:0] redir_pc;

  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] fire_addr[$];
  int          fire_cyc[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_instr[$];
  int          pop_cyc[$];

  logic        s_req_valid, s_if_valid;
  logic [31:0] s_if_pc, s_if_instr;
  int          s_cyc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0013_5A13;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
  endtask

  function automatic int first_pop_after(input int k);
    for (int i = 0; i < pop_cyc.size(); i++) if (pop_cyc[i] > k) return i;
    return -1;
  endfunction

  function automatic int first_fire_after(input int k);
    for (int i = 0; i < fire_cyc.size(); i++) if (fire_cyc[i] > k) return i;
    return -1;
  endfunction

  function automatic int pops_in_range(input logic [31:0] lo, input logic [31:0] hi);
    int n = 0;
    for (int i = 0; i < pop_pc.size(); i++) if (pop_pc[i] >= lo && pop_pc[i] < hi) n++;
    return n;
  endfunction

  // One clock cycle: drive inputs at negedge, sample #1 later, log fires and pops.
  task automatic step();
    bus.imem_req_ready = rdy_req;
    bus.if_ready       = rdy_if;
    bus.redirect_valid = redir_v;
    bus.redirect_pc    = redir_pc;
    if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(mq_addr[0]);
      mq_due.delete(0);
      mq_addr.delete(0);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'h0;
    end
    #1;
    s_cyc       = cyc;
    s_req_valid = bus.imem_req_valid;
    s_if_valid  = bus.if_valid;
    s_if_pc     = bus.if_pc;
    s_if_instr  = bus.if_instr;
    if (!reset) begin
      if (bus.imem_req_valid && rdy_req) begin
        fire_addr.push_back(bus.imem_req_addr);
        fire_cyc.push_back(cyc);
        mq_addr.push_back(bus.imem_req_addr);
        mq_due.push_back(cyc + lat);
      end
      if (bus.if_valid && rdy_if && !redir_v) begin
        pop_pc.push_back(bus.if_pc);
        pop_instr.push_back(bus.if_instr);
        pop_cyc.push_back(cyc);
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic clear_logs();
    mq_addr.delete();   mq_due.delete();
    fire_addr.delete(); fire_cyc.delete();
    pop_pc.delete();    pop_instr.delete(); pop_cyc.delete();
    cyc = 0;
  endtask

  task automatic do_reset(input int l);
    reset = 1'b1; rdy_req = 1'b0; rdy_if = 1'b0; redir_v = 1'b0; redir_pc = 32'h0;
    lat = l;
    clear_logs();
    step();
    step();
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
    chk("rst_if_valid",  32'(bus.if_valid),       32'h0);
    chk("rst_if_pc",     bus.if_pc,               32'h0);
    chk("rst_if_instr",  bus.if_instr,            32'h0);
    reset = 1'b0;
    clear_logs();
  endtask

  int k;

  initial begin
    // Test 1: streaming, latency 1.
    do_reset(1);
    rdy_req = 1'b1; rdy_if = 1'b1;
    for (int c = 0; c < 12; c++) step();
    chk("t1_fire0_addr", fire_addr[0], 32'h0);
    chk("t1_fire0_cyc",  32'(fire_cyc[0]), 32'h0);
    chk("t1_fire1_addr", fire_addr[1], 32'h4);
    chk("t1_fire2_addr", fire_addr[2], 32'h8);
    chk("t1_first_pop_cyc", 32'(pop_cyc[0]), 32'(T1_FIRST_POP));
    for (int i = 0; i < 8; i++) begin
      chk("t1_pop_pc",    pop_pc[i],      32'(4 * i));
      chk("t1_pop_instr", pop_instr[i],   mem_word(32'(4 * i)));
      chk("t1_pop_cyc",   32'(pop_cyc[i]), 32'(T1_FIRST_POP + i));
    end

    // Test 2: decode stalled for 10 cycles, then released.
    do_reset(1);
    rdy_req = 1'b1; rdy_if = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (s_cyc == 5) chk("t2_hold_pc_c5", s_if_pc, 32'h0);
    end
    chk("t2_fires",      32'(fire_addr.size()), 32'(DEPTH));
    chk("t2_req_valid",  32'(s_req_valid),      32'h0);
    chk("t2_if_valid",   32'(s_if_valid),       32'h1);
    chk("t2_hold_pc",    s_if_pc,               32'h0);
    chk("t2_hold_instr", s_if_instr,            mem_word(32'h0));
    chk("t2_no_pop",     32'(pop_pc.size()),    32'h0);
    rdy_if = 1'b1;
    for (int c = 0; c < 20; c++) step();
    for (int i = 0; i < 12; i++) begin
      chk("t2_pop_pc",    pop_pc[i],    32'(4 * i));
      chk("t2_pop_instr", pop_instr[i], mem_word(32'(4 * i)));
    end

    // Test 3: latency 3, redirect with two requests outstanding.
    do_reset(3);
    rdy_if = 1'b1; redir_pc = 32'h100;
    for (int c = 0; c < 18; c++) begin
      rdy_req = (cyc < 2) || (cyc >= 3);
      redir_v = (cyc == 2);
      step();
      if (s_cyc == 3 || s_cyc == 4) begin
        chk("t3_drain_noreq", 32'(s_req_valid), 32'h0);
        chk("t3_drain_empty", 32'(s_if_valid),  32'h0);
      end
    end
    redir_v = 1'b0;
    chk("t3_refetch_addr", fire_addr[2], 32'h100);
    chk("t3_refetch_cyc",  32'(fire_cyc[2]), 32'h5);
    chk("t3_pop0_pc",      pop_pc[0], 32'h100);
    chk("t3_pop0_instr",   pop_instr[0], mem_word(32'h100));
    chk("t3_pop1_pc",      pop_pc[1], 32'h104);
    chk("t3_no_stale",     32'(pops_in_range(32'h0, 32'h100)), 32'h0);

    // Test 4: redirect in the same cycle as pop, push and request fire.
    do_reset(1);
    rdy_req = 1'b1; rdy_if = 1'b1; redir_pc = 32'h40;
    for (int c = 0; c < 12; c++) begin
      redir_v = (cyc == 3);
      step();
      if (s_cyc == 4) begin
        chk("t4_empty_after", 32'(s_if_valid),  32'h0);
        chk("t4_drain_noreq", 32'(s_req_valid), 32'h0);
      end
    end
    redir_v = 1'b0;
    chk("t4_fire_in_redir", fire_addr[3], 32'hC);
    k = first_fire_after(3);
    chk("t4_refetch_addr", fire_addr[k], 32'h40);
    chk("t4_pre_pop",      pop_pc[0], 32'h0);
    k = first_pop_after(3);
    chk("t4_first_pc",     pop_pc[k],    32'h40);
    chk("t4_first_instr",  pop_instr[k], mem_word(32'h40));
    chk("t4_second_pc",    pop_pc[k+1],  32'h44);
    chk("t4_no_stale",     32'(pops_in_range(32'h8, 32'h10)), 32'h0);

    // Test 5: second redirect while draining the first.
    do_reset(3);
    rdy_req = 1'b1; rdy_if = 1'b1;
    for (int c = 0; c < 20; c++) begin
      redir_v  = (cyc == 2) || (cyc == 4);
      redir_pc = (cyc == 2) ? 32'h200 : 32'h300;
      step();
      if (s_cyc >= 3 && s_cyc <= 5) chk("t5_drain_noreq", 32'(s_req_valid), 32'h0);
    end
    redir_v = 1'b0;
    k = first_fire_after(4);
    chk("t5_refetch_addr", fire_addr[k], 32'h300);
    chk("t5_refetch_cyc",  32'(fire_cyc[k]), 32'h6);
    chk("t5_pop0_pc",      pop_pc[0], 32'h300);
    chk("t5_pop1_pc",      pop_pc[1], 32'h304);
    chk("t5_no_200",       32'(pops_in_range(32'h0, 32'h300)), 32'h0);

    // Test 6: PC wrap at the top of memory, then a misaligned redirect.
    do_reset(1);
    rdy_req = 1'b1; rdy_if = 1'b1;
    for (int c = 0; c < 18; c++) begin
      redir_v  = (cyc == 0) || (cyc == 10);
      redir_pc = (cyc == 0) ? 32'hFFFF_FFFC : 32'h103;
      step();
    end
    redir_v = 1'b0;
    chk("t6_fire_top",   fire_addr[1], 32'hFFFF_FFFC);
    chk("t6_fire_wrap",  fire_addr[2], 32'h0);
    chk("t6_pop_top",    pop_pc[0],    32'hFFFF_FFFC);
    chk("t6_instr_top",  pop_instr[0], mem_word(32'hFFFF_FFFC));
    chk("t6_pop_wrap",   pop_pc[1],    32'h0);
    k = first_fire_after(10);
    chk("t6_align_fire", fire_addr[k], 32'h100);
    k = first_pop_after(10);
    chk("t6_align_pop",  pop_pc[k],    32'h100);
    chk("t6_align_next", pop_pc[k+1],  32'h104);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
